l2_bus_responder: RTL
=====================

Name: l2_bus_responder

Overview:
- Responder end of the shared bus-to-L2 interface: accepts one arbitrated request at a time from the bus controller (opcode, address, write data) and returns read data plus a hit/miss status.
- Direct-mapped, write-back, write-allocate L2 with one 32-bit word per line.
- Refills and evictions go through a simple req/ack port to data memory.
- Also provides a full-cache flush sequence that writes back all dirty lines.

Parameters:
- SETS, 64, number of lines; power of 2, at least 2
- INDEX_W, $clog2(SETS), index width (derived)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  1  request valid from bus controller
- opcode_in  in  7  RISC-V opcode; 7'b0000011 = load, 7'b0100011 = store
- address_in  in  32  byte address; bits [1:0] ignored
- data_in  in  32  store data
- flush  in  1  start flush; sampled only when ready=1
- ready  out  1  responder idle, can accept req or flush
- resp_valid  out  1  one-cycle response strobe
- data_out  out  32  load data, valid with resp_valid
- cache_hit_out  out  2  status valid with resp_valid: 01 hit, 10 miss, 11 illegal opcode
- flush_done  out  1  one-cycle pulse when flush completes
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write-back, 0 = refill read
- mem_addr  out  32  word-aligned memory address
- mem_wdata  out  32  write-back data
- mem_ack  in  1  memory completion, 1 cycle
- mem_rdata  in  32  refill data, valid with mem_ack

Behaviour:
- Address split: index = address[INDEX_W+1:2]; tag = address[31:INDEX_W+2]. Per-line storage: valid, dirty, tag, data.
- Reset values:
  - all valid and dirty bits = 0; FSM = IDLE; ready = 1
  - resp_valid, flush_done, mem_req, mem_we = 0
  - data_out, mem_addr, mem_wdata = 0; cache_hit_out = 00
  - Reset mid-operation aborts immediately: mem_req drops the next cycle; no response is issued.
- Request registration: in IDLE, req=1 latches opcode, address and data. req has priority over flush when both are asserted in the same cycle. ready=0 in every state except IDLE.
- FSM states:
  - IDLE: req -> LOOKUP. flush (with no req) -> FL_SCAN with counter = 0.
  - LOOKUP:
    - Illegal opcode -> RESP with status 11; no state change.
    - Hit (valid and tag match) -> RESP with status 01. A load returns the line data; a store writes data, sets dirty=1, and returns data_out = 0.
    - Miss with victim valid and dirty -> WB.
    - Miss otherwise -> FILL for a load; store miss -> RESP.
  - WB: mem_req=1, mem_we=1, mem_addr = {victim tag, index, 2'b00}, mem_wdata = victim data. On mem_ack: load -> FILL, store -> RESP.
  - FILL: mem_req=1, mem_we=0, mem_addr = {addr[31:2], 2'b00}. On mem_ack: write line (valid=1, dirty=0, data = mem_rdata) -> RESP.
  - Store miss: line is overwritten directly with no refill (valid=1, dirty=1, new tag). Status 10.
  - Load miss: status 10; data_out = refilled word.
  - RESP: resp_valid=1 for exactly one cycle -> IDLE. data_out and cache_hit_out hold their value until the next response.
- Latency:
  - Request accepted in cycle T -> resp_valid in T+2 on a hit or a clean store miss.
  - Each memory transaction adds (cycles until mem_ack) + 1.
- Flush:
  - FL_SCAN: if line[counter] is valid and dirty -> FL_WB; else advance counter.
  - FL_WB: write back line[counter] exactly as in WB. On mem_ack: clear dirty and advance counter.
  - Lines stay valid after flush.
  - After line SETS-1 is processed (counter wraps to 0): flush_done=1 for one cycle -> IDLE.
  - Requests arriving during flush are ignored (ready=0); the bus controller must hold them.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until mem_ack.
  - mem_ack while mem_req=0 is ignored.
  - mem_req deasserts in the cycle after mem_ack.
- Same index back to back: the second request observes the first request's update (storage written by the end of RESP).

Test Plan:
- After reset, load at 0x0000_0100 with mem_rdata = 0xDEAD_BEEF -> one FILL with mem_addr = 0x100; status 10; data_out = 0xDEADBEEF. Repeat the load -> status 01, resp_valid at T+2, no mem_req.
- Store 0x1234_5678 to 0x200 (miss) -> no mem_req, status 10. Then load from 0x200 -> hit, data_out = 0x12345678.
- SETS=64: store to 0x200, then load from 0x300 (same index, different tag) -> WB with mem_addr = 0x200 and mem_wdata = stored word, then FILL with 0x300; status 10.
- Opcode 7'b0110011 -> status 11 at T+2; no storage or memory activity.
- Dirty lines at indices 0, 5 and 63, then flush -> exactly 3 writes in ascending index order, one flush_done pulse, then reloading those addresses hits with no mem_req.
- Reset asserted during FILL wait -> mem_req low the next cycle, no resp_valid, and the subsequent load of a previously cached address misses.

Source files
------------

// File: rtl/l2_bus_responder.sv
// rtl/l2_bus_responder.sv - direct-mapped write-back L2 responder with refill/evict port and full flush
module l2_bus_responder #(
    parameter int SETS    = 64,
    parameter int INDEX_W = $clog2(SETS)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [6:0]  opcode_in,
    input  logic [31:0] address_in,
    input  logic [31:0] data_in,
    input  logic        flush,
    output logic        ready,
    output logic        resp_valid,
    output logic [31:0] data_out,
    output logic [1:0]  cache_hit_out,
    output logic        flush_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int TAG_W = 30 - INDEX_W;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [1:0] ST_HIT     = 2'b01;
    localparam logic [1:0] ST_MISS    = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;
    localparam logic [INDEX_W-1:0] LAST_SET = INDEX_W'(SETS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WB, S_FILL, S_RESP, S_FL_SCAN, S_FL_WB, S_FL_DONE
    } state_t;

    state_t             state;
    logic [6:0]         op_q;
    logic [29:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [INDEX_W-1:0] cnt;

    logic [SETS-1:0]    valid_q;
    logic [SETS-1:0]    dirty_q;
    logic [TAG_W-1:0]   tag_mem  [SETS];
    logic [31:0]        data_mem [SETS];

    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               is_load;
    logic               is_store;
    logic               hit;
    logic               victim_dirty;
    logic               unused_addr_bits;

    // Byte offset bits never participate in a word-per-line cache.
    assign unused_addr_bits = ^address_in[1:0];

    assign req_idx      = addr_q[INDEX_W-1:0];
    assign req_tag      = addr_q[29:INDEX_W];
    assign is_load      = (op_q == OP_LOAD);
    assign is_store     = (op_q == OP_STORE);
    assign hit          = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            ready         <= 1'b1;
            resp_valid    <= 1'b0;
            flush_done    <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            data_out      <= '0;
            cache_hit_out <= 2'b00;
            valid_q       <= '0;
            dirty_q       <= '0;
            cnt           <= '0;
            op_q          <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
        end else begin
            resp_valid <= 1'b0;
            flush_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        op_q    <= opcode_in;
                        addr_q  <= address_in[31:2];
                        wdata_q <= data_in;
                        ready   <= 1'b0;
                        state   <= S_LOOKUP;
                    end else if (flush) begin
                        cnt   <= '0;
                        ready <= 1'b0;
                        state <= S_FL_SCAN;
                    end
                end
                S_LOOKUP: begin
                    if (!is_load && !is_store) begin
                        data_out      <= '0;
                        cache_hit_out <= ST_ILLEGAL;
                        resp_valid    <= 1'b1;
                        state         <= S_RESP;
                    end else if (hit) begin
                        if (is_store) begin
                            data_mem[req_idx] <= wdata_q;
                            dirty_q[req_idx]  <= 1'b1;
                            data_out          <= '0;
                        end else begin
                            data_out <= data_mem[req_idx];
                        end
                        cache_hit_out <= ST_HIT;
                        resp_valid    <= 1'b1;
                        state         <= S_RESP;
                    end else if (victim_dirty) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {tag_mem[req_idx], req_idx, 2'b00};
                        mem_wdata <= data_mem[req_idx];
                        state     <= S_WB;
                    end else if (is_load) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {addr_q, 2'b00};
                        state    <= S_FILL;
                    end else begin
                        // Store miss allocates without refill: the whole line is the store word.
                        valid_q[req_idx]  <= 1'b1;
                        dirty_q[req_idx]  <= 1'b1;
                        tag_mem[req_idx]  <= req_tag;
                        data_mem[req_idx] <= wdata_q;
                        data_out          <= '0;
                        cache_hit_out     <= ST_MISS;
                        resp_valid        <= 1'b1;
                        state             <= S_RESP;
                    end
                end
                S_WB: begin
                    if (mem_req && mem_ack) begin
                        mem_req <= 1'b0;
                        if (is_load) begin
                            state <= S_FILL;
                        end else begin
                            valid_q[req_idx]  <= 1'b1;
                            dirty_q[req_idx]  <= 1'b1;
                            tag_mem[req_idx]  <= req_tag;
                            data_mem[req_idx] <= wdata_q;
                            data_out          <= '0;
                            cache_hit_out     <= ST_MISS;
                            resp_valid        <= 1'b1;
                            state             <= S_RESP;
                        end
                    end
                end
                S_FILL: begin
                    // Arriving from WB, mem_req is low for one cycle between the two transactions.
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {addr_q, 2'b00};
                    end else if (mem_ack) begin
                        mem_req           <= 1'b0;
                        valid_q[req_idx]  <= 1'b1;
                        dirty_q[req_idx]  <= 1'b0;
                        tag_mem[req_idx]  <= req_tag;
                        data_mem[req_idx] <= mem_rdata;
                        data_out          <= mem_rdata;
                        cache_hit_out     <= ST_MISS;
                        resp_valid        <= 1'b1;
                        state             <= S_RESP;
                    end
                end
                S_RESP: begin
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                S_FL_SCAN: begin
                    if (valid_q[cnt] && dirty_q[cnt]) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {tag_mem[cnt], cnt, 2'b00};
                        mem_wdata <= data_mem[cnt];
                        state     <= S_FL_WB;
                    end else if (cnt == LAST_SET) begin
                        flush_done <= 1'b1;
                        state      <= S_FL_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FL_WB: begin
                    if (mem_req && mem_ack) begin
                        mem_req      <= 1'b0;
                        dirty_q[cnt] <= 1'b0;
                        if (cnt == LAST_SET) begin
                            flush_done <= 1'b1;
                            state      <= S_FL_DONE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= S_FL_SCAN;
                        end
                    end
                end
                S_FL_DONE: begin
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
